// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencing controller for the MIPS EX stage.
// Accepts mult/multu/div/divu/mthi/mtlo, runs multi-cycle ops on a busy
// down-counter, and owns the HI/LO architectural registers.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   MDOp_EX   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   MDA_EX    rs operand (forwarded)
//   MDB_EX    rt operand (forwarded)
//   MDUse_ID  instruction in ID is MD-class
//   HI, LO    architectural HI/LO registers
//   Busy      multi-cycle operation in progress
//   Start     MD arithmetic op in EX while idle (combinational)
//   MDStall   stall request for ID: MDUse_ID && (Busy || Start)
//
// state | meaning
// IDLE  | ready; accepts arithmetic ops and mthi/mtlo
// RUN   | result buffered, counting down the op latency; HI/LO held

module md_unit_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MDOp_EX,
   input  logic [31:0] MDA_EX,
   input  logic [31:0] MDB_EX,
   input  logic        MDUse_ID,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Start,
   output logic        MDStall
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] a_sext, b_sext;
   logic [63:0] prod_s, prod_u;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic        div_zero;

   assign a_sext   = {{32{MDA_EX[31]}}, MDA_EX};
   assign b_sext   = {{32{MDB_EX[31]}}, MDB_EX};
   assign prod_s   = $signed(a_sext) * $signed(b_sext);
   assign prod_u   = {32'd0, MDA_EX} * {32'd0, MDB_EX};
   assign div_zero = (MDB_EX == 32'd0);

   // Dividers are gated on a nonzero divisor so a zero divisor never
   // reaches the operators; that case keeps HI/LO via the result mux.
   always_comb begin
      quot_s = 32'd0;
      rem_s  = 32'd0;
      quot_u = 32'd0;
      rem_u  = 32'd0;
      if (!div_zero) begin
         quot_s = $signed(MDA_EX) / $signed(MDB_EX);
         rem_s  = $signed(MDA_EX) % $signed(MDB_EX);
         quot_u = MDA_EX / MDB_EX;
         rem_u  = MDA_EX % MDB_EX;
      end
   end

   assign Start   = (state_q == IDLE) && (MDOp_EX >= 3'd1) && (MDOp_EX <= 3'd4);
   assign Busy    = (state_q == RUN);
   assign MDStall = MDUse_ID && (Busy || Start);
   assign HI      = hi_q;
   assign LO      = lo_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
               case (MDOp_EX)
                  3'd1: begin
                     res_hi_d = prod_s[63:32];
                     res_lo_d = prod_s[31:0];
                     cnt_d    = MULT_N;
                  end
                  3'd2: begin
                     res_hi_d = prod_u[63:32];
                     res_lo_d = prod_u[31:0];
                     cnt_d    = MULT_N;
                  end
                  3'd3: begin
                     res_hi_d = div_zero ? hi_q : rem_s;
                     res_lo_d = div_zero ? lo_q : quot_s;
                     cnt_d    = DIV_N;
                  end
                  default: begin
                     res_hi_d = div_zero ? hi_q : rem_u;
                     res_lo_d = div_zero ? lo_q : quot_u;
                     cnt_d    = DIV_N;
                  end
               endcase
            end else if (MDOp_EX == 3'd5) begin
               hi_d = MDA_EX;
            end else if (MDOp_EX == 3'd6) begin
               lo_d = MDA_EX;
            end
         end
         RUN: begin
            // Ops arriving here are ignored; the stall keeps them out of EX.
            if (cnt_q == 4'd1) begin
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

   logic        clk;
   logic        reset;
   logic [2:0]  MDOp_EX;
   logic [31:0] MDA_EX;
   logic [31:0] MDB_EX;
   logic        MDUse_ID;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;
   logic        Start;
   logic        MDStall;

   int tests;
   int fails;

   md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .MDOp_EX  (MDOp_EX),
      .MDA_EX   (MDA_EX),
      .MDB_EX   (MDB_EX),
      .MDUse_ID (MDUse_ID),
      .HI       (HI),
      .LO       (LO),
      .Busy     (Busy),
      .Start    (Start),
      .MDStall  (MDStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Legal streams never present an MD op while the unit is busy.
   always @(posedge clk) begin
      if (!reset && Busy && MDOp_EX != 3'd0 && MDOp_EX != 3'd7) begin
         fails++;
         $display("FAIL op_while_busy: op=%0d presented with Busy=1", MDOp_EX);
      end
   end

   // Called at a negedge: drives the op for one cycle, then counts busy
   // cycles and whether HI/LO stayed at their pre-op values. Returns at the
   // negedge of the first non-busy cycle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic start_seen, output int busy_n, output logic held);
      logic [31:0] h0, l0;
      h0 = HI;
      l0 = LO;
      MDOp_EX = op;
      MDA_EX  = a;
      MDB_EX  = b;
      #1 start_seen = Start;
      @(negedge clk);
      MDOp_EX = 3'd0;
      busy_n  = 0;
      held    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!Busy) break;
         busy_n++;
         if (HI !== h0 || LO !== l0) held = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      MDOp_EX  = 3'd0;
      MDA_EX   = 32'd0;
      MDB_EX   = 32'd0;
      MDUse_ID = 1'b0;
      #1;
      tests++;
      if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || Start !== 1'b0 || MDStall !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: HI=%h LO=%h Busy=%b Start=%b MDStall=%b, need all 0",
                  HI, LO, Busy, Start, MDStall);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult();
      logic s, held;
      int n;
      do_op(3'd1, 32'hFFFF_FFFD, 32'd5, s, n, held);
      tests++;
      if (s !== 1'b1) begin
         fails++;
         $display("FAIL mult_start: Start=%b, need 1", s);
      end
      tests++;
      if (n != 5) begin
         fails++;
         $display("FAIL mult_busy_len: got %0d cycles, need 5", n);
      end
      tests++;
      if (held !== 1'b1) begin
         fails++;
         $display("FAIL mult_hold: HI/LO changed during busy");
      end
      tests++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
         fails++;
         $display("FAIL mult_result: HI=%h LO=%h, need ffffffff fffffff1", HI, LO);
      end
   endtask

   task automatic test_multu();
      logic s, held;
      int n;
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, s, n, held);
      tests++;
      if (n != 5 || HI !== 32'd1 || LO !== 32'hFFFF_FFFE) begin
         fails++;
         $display("FAIL multu: busy=%0d HI=%h LO=%h, need 5 00000001 fffffffe", n, HI, LO);
      end
   endtask

   task automatic test_divu();
      logic s, held;
      int n;
      do_op(3'd4, 32'd17, 32'd5, s, n, held);
      tests++;
      if (n != 10) begin
         fails++;
         $display("FAIL divu_busy_len: got %0d cycles, need 10", n);
      end
      tests++;
      if (HI !== 32'd2 || LO !== 32'd3 || held !== 1'b1) begin
         fails++;
         $display("FAIL divu_result: HI=%h LO=%h held=%b, need 2 3 1", HI, LO, held);
      end
   endtask

   task automatic test_div_signed();
      logic s, held;
      int n;
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, s, n, held);
      tests++;
      if (n != 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
         fails++;
         $display("FAIL div_signed: busy=%0d HI=%h LO=%h, need 10 ffffffff fffffffd", n, HI, LO);
      end
   endtask

   task automatic test_mthi_mtlo();
      MDOp_EX = 3'd5;
      MDA_EX  = 32'h1234_5678;
      #1;
      tests++;
      if (Start !== 1'b0) begin
         fails++;
         $display("FAIL mthi_start: Start=%b, need 0", Start);
      end
      @(negedge clk);
      MDOp_EX = 3'd6;
      MDA_EX  = 32'h0BAD_F00D;
      #1;
      tests++;
      if (HI !== 32'h1234_5678 || Busy !== 1'b0) begin
         fails++;
         $display("FAIL mthi: HI=%h Busy=%b, need 12345678 0", HI, Busy);
      end
      @(negedge clk);
      MDOp_EX = 3'd0;
      tests++;
      if (LO !== 32'h0BAD_F00D || HI !== 32'h1234_5678 || Busy !== 1'b0) begin
         fails++;
         $display("FAIL mtlo: HI=%h LO=%h Busy=%b, need 12345678 0badf00d 0", HI, LO, Busy);
      end
   endtask

   task automatic test_div_zero();
      logic s, held;
      int n;
      MDOp_EX = 3'd5;
      MDA_EX  = 32'h0000_AAAA;
      @(negedge clk);
      MDOp_EX = 3'd6;
      MDA_EX  = 32'h0000_5555;
      @(negedge clk);
      do_op(3'd3, 32'd1234, 32'd0, s, n, held);
      tests++;
      if (n != 10) begin
         fails++;
         $display("FAIL divzero_busy_len: got %0d cycles, need 10", n);
      end
      tests++;
      if (HI !== 32'h0000_AAAA || LO !== 32'h0000_5555) begin
         fails++;
         $display("FAIL divzero_result: HI=%h LO=%h, need 0000aaaa 00005555", HI, LO);
      end
   endtask

   task automatic test_stall();
      int stalled;
      int seen_busy;
      MDUse_ID = 1'b1;
      MDOp_EX  = 3'd1;
      MDA_EX   = 32'd3;
      MDB_EX   = 32'd4;
      #1;
      tests++;
      if (MDStall !== 1'b1) begin
         fails++;
         $display("FAIL stall_start: MDStall=%b, need 1", MDStall);
      end
      @(negedge clk);
      MDOp_EX   = 3'd0;
      stalled   = 0;
      seen_busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (!Busy) break;
         seen_busy++;
         if (MDStall === 1'b1) stalled++;
         @(negedge clk);
      end
      tests++;
      if (seen_busy != 5 || stalled != 5) begin
         fails++;
         $display("FAIL stall_busy: busy=%0d stalled=%0d, need 5 5", seen_busy, stalled);
      end
      tests++;
      if (MDStall !== 1'b0 || LO !== 32'd12 || HI !== 32'd0) begin
         fails++;
         $display("FAIL stall_release: MDStall=%b HI=%h LO=%h, need 0 0 0000000c", MDStall, HI, LO);
      end
      MDUse_ID = 1'b0;
      MDOp_EX  = 3'd1;
      @(negedge clk);
      MDOp_EX = 3'd0;
      #1;
      tests++;
      if (Busy !== 1'b1 || MDStall !== 1'b0) begin
         fails++;
         $display("FAIL stall_no_use: Busy=%b MDStall=%b, need 1 0", Busy, MDStall);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!Busy) break;
      end
   endtask

   task automatic test_reset_mid_run();
      logic s, held;
      int n;
      MDOp_EX = 3'd5;
      MDA_EX  = 32'h1111_2222;
      @(negedge clk);
      MDOp_EX = 3'd3;
      MDA_EX  = 32'd100;
      MDB_EX  = 32'd7;
      @(negedge clk);
      MDOp_EX = 3'd0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      tests++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         fails++;
         $display("FAIL reset_mid_run: Busy=%b HI=%h LO=%h, need 0 0 0", Busy, HI, LO);
      end
      @(negedge clk);
      reset = 1'b0;
      do_op(3'd1, 32'd7, 32'hFFFF_FFFA, s, n, held);
      tests++;
      if (s !== 1'b1 || n != 5 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFD6) begin
         fails++;
         $display("FAIL reset_then_mult: start=%b busy=%0d HI=%h LO=%h, need 1 5 ffffffff ffffffd6",
                  s, n, HI, LO);
      end
   endtask

   task automatic test_back_to_back();
      logic s, held;
      int n;
      do_op(3'd2, 32'd6, 32'd7, s, n, held);
      do_op(3'd4, 32'd100, 32'd9, s, n, held);
      tests++;
      if (s !== 1'b1 || n != 10 || held !== 1'b1 || HI !== 32'd1 || LO !== 32'd11) begin
         fails++;
         $display("FAIL back_to_back: start=%b busy=%0d held=%b HI=%h LO=%h, need 1 10 1 1 0000000b",
                  s, n, held, HI, LO);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_mult();
      test_multu();
      test_divu();
      test_div_signed();
      test_mthi_mtlo();
      test_div_zero();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencing controller for the multiply/divide unit (MDU) in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage and runs multi-cycle operations with a busy counter.
- Holds the HI/LO architectural registers.
- Raises a stall request so the hazard unit freezes any MD-class instruction in ID while the unit is busy or starting.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- MDOp_EX  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- MDA_EX  input  32  rs operand, already forwarded.
- MDB_EX  input  32  rt operand, already forwarded.
- MDUse_ID  input  1  the instruction in ID is MD-class: mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- HI  output  32  HI register, read by the EX-stage mfhi mux.
- LO  output  32  LO register, read by the EX-stage mflo mux.
- Busy  output  1  a multi-cycle operation is in progress.
- Start  output  1  combinational; MDOp_EX is 1..4 and the state is IDLE.
- MDStall  output  1  combinational; MDUse_ID && (Busy || Start).

Behaviour:
- Reset values: HI=0, LO=0, Busy=0, state IDLE, counter 0, result buffers 0.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, 4-bit down-counter cnt active.
- Start in IDLE: MDOp_EX in 1..4 during cycle c.
  - At the edge ending c: compute the result into the 32-bit buffers resHI/resLO.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
- Busy is 1 in cycles c+1 .. c+N, where N is the latency.
- RUN: each edge decrements cnt. At the edge ending the cycle with cnt==1:
  - HI<=resHI, LO<=resLO, state<=IDLE.
  - Busy=0 and the new HI/LO are visible from cycle c+N+1.
- HI/LO keep their old values throughout RUN; they are never partially updated.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (MDB_EX==0): the operation still occupies DIV_CYCLES; resHI/resLO are loaded with the current HI/LO, so the registers are unchanged.
- mthi/mtlo in IDLE: HI<=MDA_EX (or LO<=MDA_EX) at the edge ending that cycle, with no busy period. Start=0 for these ops.
- Any MDOp_EX!=0 while in RUN is ignored, with no state change. The pipeline guarantees this cannot happen through MDStall; the bench asserts it never does in legal streams.
- MDStall depends only on MDUse_ID, Busy and Start.
  - It covers the cycle an MD op sits in EX (Start) and every busy cycle.
  - It drops in cycle c+N+1, when the HI/LO reads are correct.
- Reset asserted mid-RUN: immediately IDLE, Busy=0, HI=LO=0. The pending result is discarded.
- Reset deassertion takes effect with the next rising edge; an op present in that cycle is accepted normally.
- The counter never wraps: it is only loaded from IDLE with N>=1 and exits at 1.

Test Plan:
- mult, A=0xFFFFFFFD (-3), B=5:
  - Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - HI/LO hold 0 during busy.
- divu, A=17, B=5:
  - Busy for 10 cycles.
  - Then LO=3, HI=2.
- div, A=0xFFFFFFF9 (-7), B=2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, A=1234, B=0, with prior HI=0xAAAA, LO=0x5555:
  - Busy for 10 cycles.
  - HI/LO unchanged afterwards.
- MDUse_ID=1 from the start cycle onward:
  - MDStall=1 in the start cycle and all 5 busy cycles of a mult.
  - MDStall=0 on the next cycle.
  - MDUse_ID=0 with Busy=1 gives MDStall=0.
- mthi 0x12345678 in IDLE:
  - HI=0x12345678 the next cycle, Busy stays 0.
- reset pulsed on busy cycle 3 of a div:
  - Busy, HI and LO go to 0 without waiting for a clock edge.
  - A new mult accepted after release completes with the correct result.
